sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM master that sequences reads of the system-ID slave after reset, or on request.
- Reads word 0 (system ID) and word 1 (build timestamp), compares both against expected values, and retries on mismatch.
- Publishes pass/fail status and the captured words to boot and status logic.
- Sits between the reset controller and the sysid slave port; it is the only master of that port.

Parameters:
- EXPECTED_ID, 32'd0, value expected at sysid address 0.
- EXPECTED_TIMESTAMP, 32'd1584655414, value expected at sysid address 1.
- MAX_RETRIES, 3, extra full read sequences after a mismatch; 0 is legal.
- TIMEOUT_CYCLES, 255, consecutive waitrequest cycles before a read is abandoned; must be ≥1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset.
- start  in  1  single-cycle pulse requesting a re-check.
- avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  sysid read data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  sequence in progress.
- done  out  1  level; result valid.
- pass  out  1  both words matched on the final attempt.
- id_mismatch  out  1  word 0 differed on the final attempt.
- ts_mismatch  out  1  word 1 differed on the final attempt.
- timeout  out  1  a read was abandoned.
- captured_id  out  32  last word-0 value read.
- captured_ts  out  32  last word-1 value read.

Behaviour:
- Interface (already decided): one clock, `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; retry_cnt 0.
  - Internal auto_start flag set to 1.
- All outputs are registered.
- States: IDLE, RD_ID, RD_TS, COMPARE, DONE.
- IDLE:
  - If auto_start=1 or start=1: clear auto_start, clear result flags, then → RD_ID.
  - The first cycle after reset release therefore transitions to RD_ID.
- RD_ID:
  - avm_read=1, avm_address=0, busy=1.
  - In a cycle with avm_waitrequest=0: latch avm_readdata into captured_id, → RD_TS.
- RD_TS:
  - avm_read=1, avm_address=1.
  - Read completion latches captured_ts, → COMPARE.
- Avalon rule: avm_read and avm_address stay stable while avm_waitrequest=1. Data is sampled only in the completing cycle.
- COMPARE (exactly 1 cycle):
  - Computes id_mismatch and ts_mismatch.
  - Both clear → DONE with pass=1.
  - Either set and retry_cnt < MAX_RETRIES → retry_cnt+1, → RD_ID.
  - Either set with retries exhausted → DONE with pass=0.
  - Mismatch flags stay visible between attempts.
- DONE:
  - busy=0, done=1; flags and captured values held.
  - start=1 clears done/pass/mismatch/timeout and retry_cnt, then → RD_ID.
- Zero-wait latency: reads complete in cycles 1 and 2 after reset release, COMPARE in cycle 3, done=1 visible from cycle 4.
- start is ignored while busy=1; it is not queued.
- start in the same cycle as reset deassertion: there is no effect beyond the auto-start.
- Asynchronous reset mid-read drops avm_read immediately. The sequence restarts via auto_start.
- retry_cnt width is $clog2(MAX_RETRIES+1); it never wraps.

Optional Feature:
- Macro: SYSID_CHECK_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to RD_ID/RD_TS and increments on each cycle with avm_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES with waitrequest still 1, the read is abandoned: avm_read=0 next cycle, → DONE with timeout=1, pass=0.
  - Timeouts are never retried.
- Undefined: no counter; reads wait indefinitely; timeout is tied 0.

Decomposition:
- Package sysid_check_pkg:
  - state enum.
  - Address constants ADDR_ID=1'b0, ADDR_TS=1'b1.
  - Default EXPECTED_* constants.
- One natural sub-module, sysid_wait_timer:
  - Parameterised saturating counter with clear/enable inputs and an expired output.
  - Instantiated only under SYSID_CHECK_TIMEOUT_EN.

Test Plan:
- Zero-wait slave returning 0 / 1584655414, release reset → reads at cycles 1–2, done=1 at cycle 4, pass=1, captured_ts=1584655414.
- Slave returns timestamp 1584655415 on every read, MAX_RETRIES=3 → 4 full sequences observed, done with pass=0, ts_mismatch=1, id_mismatch=0.
- Mismatch on the first attempt, correct values afterwards → exactly 2 sequences, pass=1, flags clear.
- waitrequest held 5 cycles on word 1 → avm_read/avm_address stable for 6 cycles, data sampled on the 6th, pass=1. With macro and TIMEOUT_CYCLES=4: timeout=1, pass=0, avm_read low within 1 cycle of expiry.
- start pulsed during RD_TS → ignored. start pulsed in DONE → done drops next cycle, new sequence, done returns.
- reset_n asserted mid-RD_ID → all outputs 0 asynchronously; after release, auto-start reads word 0 again.

Source files
------------

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid boot checker: FSM states,
// sysid word addresses and the default expected words.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEF_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'd1584655414;

    function automatic logic word_mismatch(input logic [31:0] a, input logic [31:0] b);
        return (a != b);
    endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Saturating wait-state counter; o_expired is high once MAX_COUNT
// consecutive enabled cycles have been counted since the last clear.
module sysid_wait_timer #(
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned      CNT_W   = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        w_next = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            w_next = r_count + CNT_ONE;
        end else begin
            w_next = r_count;
        end
    end

    // Count and expiry flag registered together so o_expired is glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            o_expired <= 1'b0;
        end else begin
            r_count   <= w_next;
            o_expired <= (w_next == CNT_MAX);
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads sysid words 0/1 after reset or on start, checks
// them and retries on mismatch. Read timeout enabled by SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    // A zero-width counter is not representable, so MAX_RETRIES=0 still gets one bit.
    localparam int unsigned        RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    state_t             r_state;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_auto_start;
    logic               w_in_read;
    logic               w_expired;
    logic               w_id_mm;
    logic               w_ts_mm;

    assign w_in_read = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_id_mm   = word_mismatch(captured_id, EXPECTED_ID);
    assign w_ts_mm   = word_mismatch(captured_ts, EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_en;

    // Counts consecutive stall cycles; a completed read restarts it for the next word.
    assign w_tmr_clear = !w_in_read || !avm_waitrequest;
    assign w_tmr_en    = w_in_read && avm_waitrequest;

    sysid_wait_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_retry_cnt  <= '0;
            r_auto_start <= 1'b1;
            avm_address  <= ADDR_ID;
            avm_read     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            id_mismatch  <= 1'b0;
            ts_mismatch  <= 1'b0;
            timeout      <= 1'b0;
            captured_id  <= 32'd0;
            captured_ts  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_auto_start || start) begin
                        r_auto_start <= 1'b0;
                        r_retry_cnt  <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        id_mismatch  <= 1'b0;
                        ts_mismatch  <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                        avm_read     <= 1'b1;
                        avm_address  <= ADDR_ID;
                        r_state      <= ST_RD_ID;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        if (r_state == ST_RD_ID) begin
                            captured_id <= avm_readdata;
                            avm_address <= ADDR_TS;
                            r_state     <= ST_RD_TS;
                        end else begin
                            captured_ts <= avm_readdata;
                            avm_read    <= 1'b0;
                            r_state     <= ST_COMPARE;
                        end
                    end else if (w_expired) begin
                        // Abandoned reads are final: no retry after a timeout.
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        timeout  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_COMPARE: begin
                    id_mismatch <= w_id_mm;
                    ts_mismatch <= w_ts_mm;
                    if (!w_id_mm && !w_ts_mm) begin
                        pass    <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_retry_cnt < RETRY_MAX) begin
                        r_retry_cnt <= r_retry_cnt + RETRY_ONE;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                        r_state     <= ST_RD_ID;
                    end else begin
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_retry_cnt <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ID;
                        r_state     <= ST_RD_ID;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker against a small sysid slave model with
// programmable word-1 wait states and a programmable number of bad timestamps.
module tb_sysid_boot_checker;

    localparam logic [31:0] GOOD_TS = 32'd1584655414;
    localparam logic [31:0] BAD_TS  = 32'd1584655415;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] captured_id, captured_ts;

    int vectors     = 0;
    int miscompares = 0;
    int id_reads    = 0;
    int base        = 0;
    int bad_seqs    = 0;
    int ws_ts       = 0;
    int ts_wait_cnt = 0;
    int ts_cycles   = 0;
    logic ts_bad;

    sysid_boot_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (GOOD_TS),
        .MAX_RETRIES        (3),
        .TIMEOUT_CYCLES     (4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_mismatch     (id_mismatch),
        .ts_mismatch     (ts_mismatch),
        .timeout         (timeout),
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave model: the first bad_seqs sequences since 'base' see a wrong timestamp.
    always_comb begin
        ts_bad       = ((id_reads - base) <= bad_seqs);
        avm_readdata = avm_address ? (ts_bad ? BAD_TS : GOOD_TS) : 32'd0;
    end

    assign avm_waitrequest = avm_read && avm_address && (ts_wait_cnt < ws_ts);

    always @(posedge clock) begin
        if (avm_read && avm_address) ts_wait_cnt <= ts_wait_cnt + 1;
        else                         ts_wait_cnt <= 0;
        if (reset_n && avm_read && !avm_address && !avm_waitrequest) id_reads <= id_reads + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_outs", 32'({avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout}), 32'd0);
        chk("rst_cap_ts", captured_ts, 32'd0);

        // Power-on auto-check, with a start pulse coinciding with reset release.
        base    = id_reads;
        start   = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("c1_rd_id", 32'({avm_read, avm_address, busy}), 32'b101);
        @(negedge clock);
        chk("c2_rd_ts", 32'({avm_read, avm_address, busy}), 32'b111);
        @(negedge clock);
        chk("c3_compare", 32'({avm_read, busy, done}), 32'b010);
        @(negedge clock);
        chk("c4_done", 32'({done, pass, busy}), 32'b110);
        chk("c4_cap_ts", captured_ts, GOOD_TS);
        chk("c4_cap_id", captured_id, 32'd0);
        repeat (3) @(negedge clock);
        chk("boot_seqs", 32'(id_reads - base), 32'd1);

        // Persistent timestamp mismatch: initial attempt plus three retries.
        bad_seqs = 100;
        base     = id_reads;
        pulse_start();
        chk("done_drop", 32'({done, busy}), 32'b01);
        wait_done(200);
        chk("retry_seqs", 32'(id_reads - base), 32'd4);
        chk("retry_flags", 32'({pass, id_mismatch, ts_mismatch}), 32'b001);
        chk("retry_cap_ts", captured_ts, BAD_TS);

        // Single bad attempt, then good data.
        bad_seqs = 1;
        base     = id_reads;
        pulse_start();
        wait_done(200);
        chk("recover_seqs", 32'(id_reads - base), 32'd2);
        chk("recover_flags", 32'({pass, id_mismatch, ts_mismatch}), 32'b100);

        // Five wait states on word 1.
        bad_seqs  = 0;
        ws_ts     = 5;
        ts_cycles = 0;
        base      = id_reads;
        pulse_start();
        for (int n = 0; n < 100 && !done; n++) begin
            if (avm_read && avm_address) ts_cycles++;
            @(negedge clock);
        end
        chk("ws_done", 32'(done), 32'd1);
        chk("ws_read_low", 32'(avm_read), 32'd0);
`ifdef SYSID_CHECK_TIMEOUT_EN
        chk("tmo_ts_cycles", 32'(ts_cycles), 32'd5);
        chk("tmo_flags", 32'({timeout, pass}), 32'b10);
`else
        chk("ws_ts_cycles", 32'(ts_cycles), 32'd6);
        chk("ws_flags", 32'({timeout, pass}), 32'b01);
        chk("ws_cap_ts", captured_ts, GOOD_TS);
`endif

        // start during RD_TS is dropped, not queued.
        ws_ts = 3;
        base  = id_reads;
        pulse_start();
        for (int n = 0; n < 20 && !(avm_read && avm_address); n++) @(negedge clock);
        chk("in_rd_ts", 32'({avm_read, avm_address}), 32'b11);
        pulse_start();
        wait_done(100);
        repeat (3) @(negedge clock);
        chk("ign_seqs", 32'(id_reads - base), 32'd1);
        chk("ign_flags", 32'({done, pass, busy}), 32'b110);

        // Asynchronous reset in the middle of RD_ID.
        ws_ts = 0;
        pulse_start();
        chk("pre_rst_rd_id", 32'({avm_read, avm_address, busy}), 32'b101);
        reset_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({avm_read, busy, done, pass}), 32'd0);
        chk("async_rst_cap", captured_ts, 32'd0);
        base = id_reads;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_rerun_done", 32'({done, pass}), 32'b11);
        chk("rst_rerun_seqs", 32'(id_reads - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
